// File: rtl/instr_issuer.sv
// -----------------------------------------------------------------------------
// instr_issuer
//
// Transmit side of the ctrl instruction byte interface. Requests arrive as
// {opcode, address} pairs over a valid/ready handshake and are queued in a
// small FIFO. An issue FSM pops one entry at a time and presents it to ctrl as
// a one-cycle enable strobe with the packed word on value. After every strobe
// the FSM idles for GAP_CYCLES cycles so that ctrl's decoded address settles
// before the next word arrives.
//
// Parameters
//   ADDRESS_BITS  width of the address field, value[ADDRESS_BITS-1:0]
//   INSTR_BITS    width of the opcode field, value[VALUE_BITS-1:ADDRESS_BITS]
//   FIFO_DEPTH    number of buffered requests (power of two, >= 2)
//   GAP_CYCLES    idle cycles forced after each strobe (0..15)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   req_valid    in   request present
//   req_ready    out  FIFO has a free slot (depends on the fill count only)
//   req_instr    in   opcode to issue
//   req_address  in   address to issue
//   enable       out  one-cycle strobe to ctrl.enable (registered)
//   value        out  {instr, address} to ctrl.value (registered, holds)
//   busy         out  FIFO non-empty or FSM not idle
//   err          out  sticky illegal-opcode flag
//
// Build option
//   INSTR_ISSUER_OPCODE_CHECK_EN  when defined, requests whose opcode is not
//   one-hot complete the handshake but are dropped, and err latches high
//   until reset. When undefined, every opcode is queued and err is tied low.
// -----------------------------------------------------------------------------
module instr_issuer #(
    parameter int ADDRESS_BITS = 5,
    parameter int INSTR_BITS   = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [INSTR_BITS-1:0]              req_instr,
    input  logic [ADDRESS_BITS-1:0]            req_address,
    output logic                               enable,
    output logic [INSTR_BITS+ADDRESS_BITS-1:0] value,
    output logic                               busy,
    output logic                               err
);

    localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       GAP_C   = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // An opcode is legal when exactly one bit is set.
    function automatic logic opcode_legal(input logic [INSTR_BITS-1:0] op);
        return (op != '0) && ((op & (op - INSTR_BITS'(1))) == '0);
    endfunction

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [VALUE_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [VALUE_BITS-1:0] head;

    logic accept;
    logic push;
    logic pop;

    state_t          state;
    state_t          state_n;
    logic [3:0]      gap_cnt;
    logic [3:0]      gap_n;
    logic            enable_n;
    logic [VALUE_BITS-1:0] value_n;

    // Ready depends on the registered count only, so a held request is
    // taken on the edge after a pop has freed a slot.
    assign req_ready = (count < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign head      = mem[rd_ptr];

`ifdef INSTR_ISSUER_OPCODE_CHECK_EN
    // Illegal opcodes still complete the handshake so the requester never
    // stalls on them; they simply never reach the FIFO.
    assign push = accept && opcode_legal(req_instr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !opcode_legal(req_instr)) begin
            err <= 1'b1;
        end
    end
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    // Entry storage carries data only and is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_instr, req_address};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
            enable  <= 1'b0;
            value   <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            enable  <= enable_n;
            value   <= value_n;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: next state and registered-output inputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        gap_n    = gap_cnt;
        enable_n = 1'b0;
        value_n  = value;
        pop      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (count != '0) begin
                    enable_n = 1'b1;
                    value_n  = head;
                    pop      = 1'b1;
                    state_n  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // enable drops here in every case. With no gap configured
                // the return through IDLE still gives one low cycle, so the
                // strobe stays a single-cycle pulse and the spacing between
                // strobes is GAP_CYCLES + 2 in both configurations.
                if (GAP_CYCLES > 0) begin
                    gap_n   = GAP_C;
                    state_n = S_GAP;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_GAP: begin
                gap_n = gap_cnt - 4'd1;
                if (gap_cnt <= 4'd1) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (count != '0) || (state != S_IDLE);

endmodule
